// File: rtl/inst_timing_if.sv
// Instruction-timing bus: sequencer-side inputs and the timing outputs that
// inst_timing reports back. The master drives the inputs, the slave is the
// timing block itself.
interface inst_timing_if;
  logic       sync;
  logic [7:0] data_in;
  logic       rdy;
  logic       page_cross;
  logic       branch_taken;
  logic       irq_req;
  logic [7:0] ir;
  logic [2:0] t_cnt;
  logic       next_sync;
  logic       illegal;

  modport master (
    output sync, data_in, rdy, page_cross, branch_taken, irq_req,
    input  ir, t_cnt, next_sync, illegal
  );

  modport slave (
    input  sync, data_in, rdy, page_cross, branch_taken, irq_req,
    output ir, t_cnt, next_sync, illegal
  );
endinterface

// File: rtl/inst_timing.sv
// NMOS 6502 instruction-cycle timing tracker.
// Latches the opcode on the fetch cycle, counts instruction cycles, and
// raises next_sync in the last cycle so the sequencer can fetch the next
// opcode. Indexed reads and taken branches stretch the instruction by one
// cycle each, as on the real part.
// Optional feature: define INST_TIMING_IRQ_EN to substitute BRK (8'h00) for
// the fetched opcode when irq_req is high at the fetch cycle. Without it,
// irq_req is ignored.
module inst_timing (
  input  logic              clk,
  input  logic              rst_n,
  inst_timing_if.slave      bus
);

  typedef struct packed {
    logic [2:0] len;     // base instruction length in cycles
    logic       rd_idx;  // abs,X / abs,Y / (zp),Y read: page cross adds a cycle
    logic       branch;  // relative branch
    logic       legal;   // documented opcode
  } dec_t;

  // Opcode layout is aaabbbcc; length follows from group (cc), addressing
  // mode (bbb) and operation (aaa).
  function automatic dec_t decode(input logic [7:0] op);
    dec_t       d;
    logic [2:0] a;
    logic [2:0] b;
    logic       rmw;
    a   = op[7:5];
    b   = op[4:2];
    rmw = (a != 3'd4) && (a != 3'd5);  // cc=10: all but STX/LDX modify memory
    d        = '0;
    d.len    = 3'd2;
    case (op[1:0])
      2'b01: begin
        d.legal = (op != 8'h89);
        case (b)
          3'd0: d.len = 3'd6;
          3'd1: d.len = 3'd3;
          3'd2: d.len = 3'd2;
          3'd3: d.len = 3'd4;
          3'd4: begin
            d.len    = (a == 3'd4) ? 3'd6 : 3'd5;
            d.rd_idx = (a != 3'd4);
          end
          3'd5: d.len = 3'd4;
          default: begin
            d.len    = (a == 3'd4) ? 3'd5 : 3'd4;
            d.rd_idx = (a != 3'd4);
          end
        endcase
      end
      2'b10: begin
        case (b)
          3'd0: d.legal = (a == 3'd5);
          3'd1: begin d.legal = 1'b1; d.len = rmw ? 3'd5 : 3'd3; end
          3'd2: d.legal = 1'b1;
          3'd3: begin d.legal = 1'b1; d.len = rmw ? 3'd6 : 3'd4; end
          3'd4: d.legal = 1'b0;
          3'd5: begin d.legal = 1'b1; d.len = rmw ? 3'd6 : 3'd4; end
          3'd6: d.legal = (a == 3'd4) || (a == 3'd5);
          default: begin
            if (rmw) begin
              d.legal = 1'b1;
              d.len   = 3'd7;
            end else if (a == 3'd5) begin
              d.legal  = 1'b1;
              d.len    = 3'd4;
              d.rd_idx = 1'b1;
            end
          end
        endcase
      end
      2'b00: begin
        case (b)
          3'd0: begin
            d.legal = (a != 3'd4);
            if (a == 3'd0)      d.len = 3'd7;
            else if (a <= 3'd3) d.len = 3'd6;
          end
          3'd1: begin
            d.legal = (a == 3'd1) || (a >= 3'd4);
            d.len   = 3'd3;
          end
          3'd2: begin
            d.legal = 1'b1;
            if ((a == 3'd0) || (a == 3'd2))      d.len = 3'd3;
            else if ((a == 3'd1) || (a == 3'd3)) d.len = 3'd4;
          end
          3'd3: begin
            d.legal = (a != 3'd0);
            if (a == 3'd2)      d.len = 3'd3;
            else if (a == 3'd3) d.len = 3'd5;
            else                d.len = 3'd4;
          end
          3'd4: begin d.legal = 1'b1; d.branch = 1'b1; end
          3'd5: begin
            d.legal = (a == 3'd4) || (a == 3'd5);
            d.len   = 3'd4;
          end
          3'd6: d.legal = 1'b1;
          default: begin
            if (a == 3'd5) begin
              d.legal  = 1'b1;
              d.len    = 3'd4;
              d.rd_idx = 1'b1;
            end
          end
        endcase
      end
      default: d.legal = 1'b0;
    endcase
    // Undocumented opcodes run as plain two-cycle instructions.
    if (!d.legal) begin
      d.len    = 3'd2;
      d.rd_idx = 1'b0;
      d.branch = 1'b0;
    end
    return d;
  endfunction

  logic [7:0] ir_q, ir_d;
  logic [2:0] t_cnt_q, t_cnt_d;
  logic       page_ext_q, page_ext_d;
  logic       br_ext_q, br_ext_d;
  logic       illegal_q, illegal_d;
  logic       boot_q, boot_d;

  logic [7:0] opcode_in;
  dec_t       dec_cur;
  dec_t       dec_in;
  logic       page_now;
  logic       br_take_now;
  logic       br_page_now;
  logic       pg_eff;
  logic       br_eff;
  logic [2:0] l_eff;

`ifdef INST_TIMING_IRQ_EN
  assign opcode_in = bus.irq_req ? 8'h00 : bus.data_in;
`else
  logic unused_irq_req;
  assign unused_irq_req = bus.irq_req;
  assign opcode_in      = bus.data_in;
`endif

  // Decode the running opcode and work out the effective length, including
  // extensions reported in this very cycle so next_sync never fires early.
  always_comb begin
    dec_cur     = decode(ir_q);
    dec_in      = decode(opcode_in);
    page_now    = dec_cur.rd_idx && bus.page_cross && (t_cnt_q == dec_cur.len);
    br_take_now = dec_cur.branch && bus.branch_taken && (t_cnt_q == 3'd2);
    br_page_now = dec_cur.branch && br_ext_q && bus.page_cross && (t_cnt_q == 3'd3);
    pg_eff      = page_ext_q || page_now || br_page_now;
    br_eff      = br_ext_q || br_take_now;
    l_eff       = dec_cur.len + {2'b00, pg_eff} + {2'b00, br_eff};
  end

  // Next-state: a fetch restarts the instruction, otherwise count and
  // collect extensions; rdy=0 freezes everything.
  always_comb begin
    ir_d       = ir_q;
    t_cnt_d    = t_cnt_q;
    page_ext_d = page_ext_q;
    br_ext_d   = br_ext_q;
    illegal_d  = illegal_q;
    boot_d     = boot_q;
    if (bus.rdy) begin
      boot_d = 1'b0;
      if (bus.sync) begin
        ir_d       = opcode_in;
        t_cnt_d    = 3'd2;
        page_ext_d = 1'b0;
        br_ext_d   = 1'b0;
        illegal_d  = !dec_in.legal;
      end else begin
        if (t_cnt_q != 3'd7) t_cnt_d = t_cnt_q + 3'd1;
        if (page_now || br_page_now) page_ext_d = 1'b1;
        if (br_take_now) br_ext_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any instruction in flight and arms boot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q       <= 8'hEA;
      t_cnt_q    <= 3'd1;
      page_ext_q <= 1'b0;
      br_ext_q   <= 1'b0;
      illegal_q  <= 1'b0;
      boot_q     <= 1'b1;
    end else begin
      ir_q       <= ir_d;
      t_cnt_q    <= t_cnt_d;
      page_ext_q <= page_ext_d;
      br_ext_q   <= br_ext_d;
      illegal_q  <= illegal_d;
      boot_q     <= boot_d;
    end
  end

  assign bus.ir        = ir_q;
  assign bus.t_cnt     = t_cnt_q;
  assign bus.illegal   = illegal_q;
  assign bus.next_sync = bus.rdy && (boot_q || (!bus.sync && (t_cnt_q == l_eff)));

endmodule
